// File: rtl/gshare_predictor.sv
// rtl/gshare_predictor.sv - gshare branch predictor: PC xor speculative GHR into saturating counters
module gshare_predictor #(
    parameter int INDEX_WIDTH = 6,
    parameter int HIST_WIDTH  = 4,
    parameter int CTR_WIDTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  query_valid,
    input  logic [31:0]           query_pc,
    output logic                  predict_result,
    output logic [HIST_WIDTH-1:0] predict_ghr,
    input  logic                  update,
    input  logic [31:0]           update_pc,
    input  logic [HIST_WIDTH-1:0] update_ghr,
    input  logic                  update_result,
    input  logic                  update_mispredict,
    output logic [31:0]           update_count,
    output logic [31:0]           mispredict_count
);
    localparam int ENTRIES = 1 << INDEX_WIDTH;
    localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
    localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;

    logic [CTR_WIDTH-1:0]   ctr_q [ENTRIES];
    logic [HIST_WIDTH-1:0]  ghr_q, ghr_d;
    logic [31:0]            update_count_q, mispredict_count_q;
    logic [INDEX_WIDTH-1:0] query_idx, update_idx;
    logic [CTR_WIDTH-1:0]   upd_ctr_cur, upd_ctr_d;
    logic                   unused_pc_bits;

    // Shorter histories are zero-extended before folding into the PC bits.
    assign query_idx  = query_pc[INDEX_WIDTH:1] ^ INDEX_WIDTH'(ghr_q);
    assign update_idx = update_pc[INDEX_WIDTH:1] ^ INDEX_WIDTH'(update_ghr);

    assign predict_result   = ctr_q[query_idx][CTR_WIDTH-1];
    assign predict_ghr      = ghr_q;
    assign update_count     = update_count_q;
    assign mispredict_count = mispredict_count_q;

    assign unused_pc_bits = ^{query_pc[31:INDEX_WIDTH+1], query_pc[0],
                              update_pc[31:INDEX_WIDTH+1], update_pc[0]};

    // The extra bit keeps the shift legal when HIST_WIDTH is 1.
    function automatic logic [HIST_WIDTH-1:0] shift_in(input logic [HIST_WIDTH-1:0] h,
                                                       input logic b);
        logic [HIST_WIDTH:0] w;
        w = {h, b};
        return w[HIST_WIDTH-1:0];
    endfunction

    always_comb begin
        upd_ctr_cur = ctr_q[update_idx];
        upd_ctr_d   = upd_ctr_cur;
        if (update_result) begin
            if (upd_ctr_cur != CTR_MAX) upd_ctr_d = upd_ctr_cur + 1'b1;
        end else begin
            if (upd_ctr_cur != '0) upd_ctr_d = upd_ctr_cur - 1'b1;
        end
    end

    // Misprediction recovery wins over the speculative shift of a concurrent query.
    always_comb begin
        ghr_d = ghr_q;
        if (update && update_mispredict) begin
            ghr_d = shift_in(update_ghr, update_result);
        end else if (query_valid) begin
            ghr_d = shift_in(ghr_q, predict_result);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_INIT;
            ghr_q              <= '0;
            update_count_q     <= '0;
            mispredict_count_q <= '0;
        end else if (rdy) begin
            ghr_q <= ghr_d;
            if (update) begin
                ctr_q[update_idx] <= upd_ctr_d;
                update_count_q    <= update_count_q + 32'd1;
                if (update_mispredict) mispredict_count_q <= mispredict_count_q + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_gshare_predictor.sv
// tb/tb_gshare_predictor.sv - scoreboard bench for gshare_predictor against an array-based model
module tb_gshare_predictor;
    localparam int IW = 6;
    localparam int HW = 4;
    localparam int CW = 3;
    localparam int ENTRIES = 1 << IW;
    localparam int CMAX = (1 << CW) - 1;
    localparam int CINIT = (1 << (CW - 1)) - 1;

    logic          clk = 1'b0;
    logic          rst, rdy, query_valid, update, update_result, update_mispredict;
    logic [31:0]   query_pc, update_pc;
    logic [HW-1:0] update_ghr;
    logic          predict_result;
    logic [HW-1:0] predict_ghr;
    logic [31:0]   update_count, mispredict_count;

    always #5 clk = ~clk;

    gshare_predictor #(.INDEX_WIDTH(IW), .HIST_WIDTH(HW), .CTR_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .query_valid(query_valid), .query_pc(query_pc),
        .predict_result(predict_result), .predict_ghr(predict_ghr),
        .update(update), .update_pc(update_pc), .update_ghr(update_ghr),
        .update_result(update_result), .update_mispredict(update_mispredict),
        .update_count(update_count), .mispredict_count(mispredict_count)
    );

    typedef struct {
        logic        pred;
        logic [31:0] ghr;
        logic [31:0] ucnt;
        logic [31:0] mcnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    int          m_tbl[ENTRIES];
    int          m_ghr;
    int unsigned m_uc, m_mc;
    bit          m_valid = 0;

    function automatic int idx_of(input logic [31:0] pc, input int h);
        int unsigned p;
        p = pc >> 1;
        return int'(p % ENTRIES) ^ h;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("predict_result", {31'd0, predict_result}, {31'd0, e.pred});
            check("predict_ghr", {{(32-HW){1'b0}}, predict_ghr}, e.ghr);
            check("update_count", update_count, e.ucnt);
            check("mispredict_count", mispredict_count, e.mcnt);
        end
    end

    task automatic cycle(input logic r, input logic rd, input logic qv, input logic [31:0] qpc,
                         input logic up, input logic [31:0] upc, input logic [HW-1:0] ughr,
                         input logic ures, input logic umis);
        exp_t e;
        bit   pred;
        int   t;
        rst = r; rdy = rd; query_valid = qv; query_pc = qpc;
        update = up; update_pc = upc; update_ghr = ughr;
        update_result = ures; update_mispredict = umis;
        pred = m_tbl[idx_of(qpc, m_ghr)] > CINIT;
        if (m_valid) begin
            e.pred = pred;
            e.ghr  = 32'(m_ghr);
            e.ucnt = m_uc;
            e.mcnt = m_mc;
            sb_q.push_back(e);
        end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < ENTRIES; i++) m_tbl[i] = CINIT;
            m_ghr = 0; m_uc = 0; m_mc = 0; m_valid = 1;
        end else if (rd) begin
            if (up) begin
                t = idx_of(upc, int'(ughr));
                m_tbl[t] = ures ? ((m_tbl[t] < CMAX) ? m_tbl[t] + 1 : CMAX)
                                : ((m_tbl[t] > 0) ? m_tbl[t] - 1 : 0);
                m_uc++;
                if (umis) m_mc++;
            end
            if (up && umis) m_ghr = (int'(ughr) * 2 + int'(ures)) % (1 << HW);
            else if (qv) m_ghr = (m_ghr * 2 + int'(pred)) % (1 << HW);
        end
        #1;
    endtask

    initial begin
        cycle(1, 0, 0, 32'h100, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 32'h100, 0, 0, 0, 0, 0);
        // training, then history separation
        cycle(0, 1, 0, 32'h100, 1, 32'h100, 0, 1, 0);
        cycle(0, 1, 0, 32'h100, 1, 32'h100, 0, 1, 0);
        cycle(0, 1, 1, 32'h100, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 32'h100, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 32'h100, 0, 0, 0, 0, 0);
        // recovery overrides a concurrent query
        cycle(0, 1, 1, 32'h104, 1, 32'h200, 4'b0000, 1, 1);
        cycle(0, 1, 1, 32'h100, 0, 0, 0, 0, 1);
        // stall
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 32'h100, 1, 32'h100, 4'h1, 1, 1);
        cycle(0, 1, 1, 32'h100, 1, 32'h100, 4'h1, 1, 1);
        cycle(0, 1, 0, 32'h100, 0, 0, 0, 0, 0);
        // saturation through a single entry, queried at GHR 0
        cycle(1, 1, 0, 32'h40, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, 32'h40, 1, 32'h40, 0, 1, 0);
        for (int i = 0; i < 10; i++) cycle(0, 1, 0, 32'h40, 1, 32'h40, 0, 0, 0);
        cycle(0, 1, 0, 32'h40, 0, 0, 0, 0, 0);
        // random traffic with occasional stalls and resets
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] qpc, upc;
            qpc = {$urandom_range(0, 3) == 0 ? 25'($urandom) : 25'd0, 6'($urandom), 1'b0};
            upc = {$urandom_range(0, 3) == 0 ? 25'($urandom) : 25'd0, 6'($urandom), 1'b0};
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 5) != 0,
                  1'($urandom), qpc, $urandom_range(0, 2) != 0, upc, HW'($urandom),
                  1'($urandom), $urandom_range(0, 3) == 0);
        end
        rst = 0; rdy = 0; query_valid = 0; update = 0;
        @(negedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
